// File: rtl/saturn_bus_ctrl_pkg.sv
// saturn_bus_ctrl_pkg: shared widths, bus command encodings, FSM and mode types
package saturn_bus_ctrl_pkg;
    localparam int ADDR_W = 20;
    localparam int LEN_W = 4;
    localparam int CNT_W = LEN_W + 1;

    localparam logic [3:0] BUSCMD_PC_READ = 4'h2;
    localparam logic [3:0] BUSCMD_DP_READ = 4'h3;
    localparam logic [3:0] BUSCMD_LOAD_PC = 4'h6;
    localparam logic [3:0] BUSCMD_LOAD_DP = 4'h7;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DRAIN} state_t;
    typedef enum logic [1:0] {MODE_NONE, MODE_PC, MODE_DP} mode_t;

    function automatic mode_t mode_of(input logic is_dp);
        return is_dp ? MODE_DP : MODE_PC;
    endfunction

    function automatic logic is_read(input logic [3:0] c);
        return c == BUSCMD_PC_READ || c == BUSCMD_DP_READ;
    endfunction
endpackage

// File: rtl/saturn_bus_ctrl_if.sv
// saturn_bus_ctrl_if: core request/response and slave nibble-bus signals
interface saturn_bus_ctrl_if;
    import saturn_bus_ctrl_pkg::*;
    logic clk_en;
    logic flush;
    logic req_valid;
    logic req_is_dp;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0] req_len;
    logic req_ready;
    logic rd_valid;
    logic [3:0] rd_nibble;
    logic busy;
    logic bus_clk_en;
    logic bus_is_data;
    logic [3:0] bus_nibble_out;
    logic [3:0] bus_nibble_in;

    modport master (
        input clk_en, flush, req_valid, req_is_dp, req_addr, req_len, bus_nibble_in,
        output req_ready, rd_valid, rd_nibble, busy, bus_clk_en, bus_is_data, bus_nibble_out
    );
    modport slave (
        output clk_en, flush, req_valid, req_is_dp, req_addr, req_len, bus_nibble_in,
        input req_ready, rd_valid, rd_nibble, busy, bus_clk_en, bus_is_data, bus_nibble_out
    );
endinterface

// File: rtl/saturn_bus_ptr_shadow.sv
// saturn_bus_ptr_shadow: shadow copies of the slave PC/DP pointers and the slave read mode
module saturn_bus_ptr_shadow
    import saturn_bus_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic is_dp,
    input  logic [ADDR_W-1:0] addr,
    output logic ptr_hit,
    output logic mode_hit,
    input  logic upd,
    input  logic upd_is_dp,
    input  logic [ADDR_W-1:0] upd_addr
);
    logic [1:0][ADDR_W-1:0] ptr;
    logic [1:0] valid;
    mode_t mode;

    assign ptr_hit = valid[is_dp] && ptr[is_dp] == addr;
    assign mode_hit = mode == mode_of(is_dp);

    // record the post-transfer pointer; a flush on the same edge still invalidates it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            valid <= '0;
            mode <= MODE_NONE;
        end else begin
            if (upd) begin
                ptr[upd_is_dp] <= upd_addr;
                valid[upd_is_dp] <= 1'b1;
                mode <= mode_of(upd_is_dp);
            end
            if (flush)
                valid <= '0;
        end
    end
endmodule

// File: rtl/saturn_bus_ctrl.sv
// saturn_bus_ctrl: nibble-bus master turning core read requests into command/address/data slots
module saturn_bus_ctrl
    import saturn_bus_ctrl_pkg::*;
(
    input logic clk,
    input logic rst_n,
    saturn_bus_ctrl_if.master bus
);
    state_t state, state_nx;
    logic is_dp;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0] cnt, rem;
    logic [2:0] pos;
    logic [3:0] cmd;
    logic ptr_hit, mode_hit, start, sample;

    assign start = bus.clk_en && bus.req_valid && state == ST_IDLE;
    // the slave returns data one slot late, so the first DATA slot has nothing to capture
    assign sample = bus.clk_en && ((state == ST_DATA && rem != cnt) || state == ST_DRAIN);

    saturn_bus_ptr_shadow u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .is_dp     (bus.req_is_dp),
        .addr      (bus.req_addr),
        .ptr_hit   (ptr_hit),
        .mode_hit  (mode_hit),
        .upd       (bus.clk_en && state == ST_DRAIN),
        .upd_is_dp (is_dp),
        .upd_addr  (addr + ADDR_W'(cnt))
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // next state and slot outputs decoded from the registered state
    always_comb begin
        state_nx = state;
        bus.req_ready = state == ST_IDLE;
        bus.busy = state != ST_IDLE;
        bus.bus_clk_en = state inside {ST_CMD, ST_ADDR, ST_DATA};
        bus.bus_is_data = state inside {ST_ADDR, ST_DATA};
        bus.bus_nibble_out = state == ST_CMD ? cmd : state == ST_ADDR ? 4'(addr >> {pos, 2'b00}) : 4'h0;
        if (bus.clk_en)
            unique case (state)
                ST_IDLE:  if (bus.req_valid) state_nx = ptr_hit && mode_hit ? ST_DATA : ST_CMD;
                ST_CMD:   state_nx = is_read(cmd) ? ST_DATA : ST_ADDR;
                ST_ADDR:  if (pos == 3'd4) state_nx = ST_DATA;
                ST_DATA:  if (rem == CNT_W'(1)) state_nx = ST_DRAIN;
                ST_DRAIN: state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
    end

    // request latch, slot counters and returned-nibble capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_dp <= 1'b0;
            addr <= '0;
            cnt <= '0;
            rem <= '0;
            pos <= '0;
            cmd <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_nibble <= '0;
        end else begin
            bus.rd_valid <= 1'b0;
            if (start) begin
                is_dp <= bus.req_is_dp;
                addr <= bus.req_addr;
                cnt <= CNT_W'(bus.req_len) + 1'b1;
                rem <= CNT_W'(bus.req_len) + 1'b1;
                pos <= '0;
                cmd <= ptr_hit ? (bus.req_is_dp ? BUSCMD_DP_READ : BUSCMD_PC_READ)
                               : (bus.req_is_dp ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC);
            end
            if (bus.clk_en && state == ST_ADDR)
                pos <= pos + 1'b1;
            if (bus.clk_en && state == ST_DATA)
                rem <= rem - 1'b1;
            if (sample) begin
                bus.rd_valid <= 1'b1;
                bus.rd_nibble <= bus.bus_nibble_in;
            end
        end
    end
endmodule
